async_fifo_wr_arb: RTL and testbench
====================================

# async_fifo_wr_arb

Round-robin write-port arbiter in the `wclk` domain that shares the single write port (`winc`/`wdata`/`wfull`) of `async_fifo` among `NREQ` packet-producing requesters. A grant is held for a whole packet, ending on `last` (or on a burst limit when compiled in), so packets from different requesters never interleave in the FIFO. The block sits directly in front of `async_fifo` and is the only driver of its write port.

## Interface
- `DSIZE`, 8, word width; matches `async_fifo` `DSIZE`.
- `NREQ`, 4, number of requesters, 2..16.
- `MAX_BURST`, 16, maximum words per grant when the burst limit is compiled in; ≥1.
- Derived: `OW = $clog2(NREQ)`.
- Clock and reset: one clock; reset is synchronous and active-high.
- `wclk`  in  1  write-domain clock; all state updates on its rising edge.
- `wrst`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  per-requester word-valid; held until the word is acked.
- `last`  in  NREQ  per-requester end-of-packet flag, qualified by `req`.
- `din`  in  NREQ*DSIZE  per-requester word; requester i uses bits `[i*DSIZE +: DSIZE]`.
- `ack`  out  NREQ  one-hot; word of requester i written this cycle.
- `wfull`  in  1  from `async_fifo`.
- `winc`  out  1  to `async_fifo`.
- `wdata`  out  DSIZE  to `async_fifo`.
- `busy`  out  1  grant held (state GRANT).
- `owner`  out  OW  index of the current grant holder.

## Operation
- State machine with two states, IDLE and GRANT, plus round-robin pointer `ptr` (OW bits).
- IDLE: at the clock edge, if any `req` bit is set, select the first set bit searching `ptr`, `ptr+1`, …, wrapping modulo NREQ. Load `owner` with it and go to GRANT. If no bit is set, stay in IDLE.
- GRANT write condition: `winc = busy & req[owner] & ~wfull & ~wrst`, combinational.
  - `wdata` = owner's `din` slice when `winc`=1, else 0.
  - `ack[owner] = winc`; all other `ack` bits are 0.
- Release: on a cycle with `winc`=1 and `last[owner]`=1:
  - next state IDLE;
  - `ptr <= owner+1` modulo NREQ (wraps NREQ-1 → 0).
- There is one IDLE bubble between packets; no grant is issued in the release cycle.
- Owner drops `req` mid-packet: the grant is held and `winc`=0 until `req` returns. There is no timeout.
- `wfull`=1: `winc`=0 and the grant is held. The write resumes in the first cycle `wfull`=0. No word is ever presented with `winc`=1 while `wfull`=1.
- Non-owner `req`/`last` are ignored during GRANT.
- The `last` of a word arriving in IDLE is honoured only once that word is written in GRANT. A single-word packet therefore occupies 2 cycles (arbitrate, write).
- Reset (including mid-packet):
  - `winc` and `ack` are forced to 0 in every cycle `wrst`=1.
  - On the edge: state IDLE, `ptr`=0, `owner`=0, burst count=0.
  - The partial packet is abandoned; the requester restarts it.
- Reset values: `winc`=0, `ack`=0, `wdata`=0, `busy`=0, `owner`=0.

## Timing
- `req` seen at edge N (IDLE) → `busy`=1 and `owner` valid after edge N. First write in cycle N+1 if `wfull`=0.
- Throughput inside a packet: 1 word/cycle while `req[owner]`=1 and `wfull`=0.
- Release: last word written in cycle M → `busy`=0 in cycle M+1 → next owner's first write in cycle M+2 at the earliest.
- The `wfull`→`winc` and `req`→`ack` paths are combinational (zero-cycle). Requesters must not feed `ack` combinationally back into `req`.
- `busy` and `owner` are registered.

## Configuration
- `ASYNC_FIFO_WR_ARB_BURST_LIMIT_EN` defined:
  - A burst counter (`$clog2(MAX_BURST+1)` bits) counts acked words in the current grant and clears on release and reset.
  - The grant also releases on the MAX_BURST-th ack even if `last`=0.
  - `ptr` advances as for a normal release, and the interrupted requester re-arbitrates for its remaining words.
- Undefined: no counter; `MAX_BURST` is unused; a grant is held until `last`.

## Test plan
- Single requester, NREQ=4: `req[2]` 3 words 0x11/0x22/0x33 with `last` on 0x33 → grant first cycle after `req`, `winc` 3 consecutive cycles, `owner`=2, `busy` falls the cycle after 0x33, `ptr`=3.
- Fairness: `req[0..3]` all held with 2-word packets, `ptr`=0 → grant order 0,1,2,3,0 with 1 bubble between packets; FIFO contents grouped per requester, never interleaved.
- Back-pressure: `wfull` held high 5 cycles mid-packet → `winc`=0 and `ack`=0 for exactly those cycles, `owner` unchanged, no word lost or duplicated (read side compares against a scoreboard).
- Wrap-around: owner 3 releases → `ptr`=0; with `req[0]` and `req[3]` both set → requester 0 granted next.
- Reset mid-packet: `wrst`=1 for 1 cycle after 2 of 4 words → `winc`=0 in that cycle; next cycle `busy`=0, `owner`=0, `ptr`=0; the restarted packet is fully written.
- With `ASYNC_FIFO_WR_ARB_BURST_LIMIT_EN`, MAX_BURST=4: `req[1]` 6-word packet, `req[2]` pending → 4 words from 1, bubble, requester 2's packet, bubble, remaining 2 words from 1. Without the macro: all 6 words from 1 first.

Source files
------------

// File: rtl/async_fifo_wr_arb.sv
// Round-robin, packet-granular arbiter sharing the async_fifo write port among NREQ requesters.
// Define ASYNC_FIFO_WR_ARB_BURST_LIMIT_EN to also end a grant after MAX_BURST words.
//
// state | meaning
// IDLE  | no grant; round-robin search from ptr picks the next owner
// GRANT | owner holds the write port until its last word (or burst limit)
module async_fifo_wr_arb #(
  parameter int DSIZE     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 16,
  localparam int OW       = $clog2(NREQ)
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       last,
  input  logic [NREQ*DSIZE-1:0] din,
  output logic [NREQ-1:0]       ack,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic                  busy,
  output logic [OW-1:0]         owner
);

  if (NREQ < 2 || NREQ > 16 || MAX_BURST < 1) begin : g_param_check
    $error("async_fifo_wr_arb: NREQ must be 2..16 and MAX_BURST >= 1");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [OW:0] NREQ_W = (OW+1)'(NREQ);

  state_t           state_q, state_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [DSIZE-1:0] din_arr [NREQ];
  logic [OW:0]      cand;
  logic [OW-1:0]    pick;
  logic [OW-1:0]    owner_inc;
  logic             found;
  logic             rel;

  for (genvar g = 0; g < NREQ; g++) begin : g_din
    assign din_arr[g] = din[g*DSIZE +: DSIZE];
  end

  // First requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + (OW+1)'(i);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!found && req[cand[OW-1:0]]) begin
        found = 1'b1;
        pick  = cand[OW-1:0];
      end
    end
  end

  assign owner_inc = (owner_q == OW'(NREQ-1)) ? '0 : owner_q + 1'b1;

`ifdef ASYNC_FIFO_WR_ARB_BURST_LIMIT_EN
  localparam int BW = $clog2(MAX_BURST+1);

  logic [BW-1:0] burst_q, burst_d;

  // Release on the MAX_BURST-th ack: counter already holds MAX_BURST-1 words.
  assign rel = winc && (last[owner_q] || (burst_q == BW'(MAX_BURST-1)));

  always_comb begin
    burst_d = burst_q;
    if (state_q == IDLE || rel) burst_d = '0;
    else if (winc)              burst_d = burst_q + 1'b1;
  end

  always_ff @(posedge wclk) begin
    if (wrst) burst_q <= '0;
    else      burst_q <= burst_d;
  end
`else
  assign rel = winc && last[owner_q];
`endif

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          owner_d = pick;
        end
      end
      GRANT: begin
        if (rel) begin
          state_d = IDLE;
          ptr_d   = owner_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    winc  = 1'b0;
    wdata = '0;
    ack   = '0;
    if (state_q == GRANT && req[owner_q] && !wfull && !wrst) winc = 1'b1;
    if (winc) begin
      wdata        = din_arr[owner_q];
      ack[owner_q] = 1'b1;
    end
  end

  assign busy  = (state_q == GRANT);
  assign owner = owner_q;

endmodule

// File: tb/tb_async_fifo_wr_arb.sv
// Directed bench for async_fifo_wr_arb: per-requester word queues drive req/last/din,
// every accepted write is logged and compared with hand-derived sequences.
module tb_async_fifo_wr_arb;
  localparam int DSIZE = 8;
  localparam int NREQ = 4;
  localparam int MAX_BURST = 4;

  logic        wclk = 1'b0;
  logic        wrst, wfull, winc, busy;
  logic [3:0]  req, last, ack;
  logic [31:0] din;
  logic [7:0]  wdata;
  logic [1:0]  owner;

  always #5 wclk = ~wclk;

  async_fifo_wr_arb #(.DSIZE(DSIZE), .NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
    .wclk(wclk), .wrst(wrst), .req(req), .last(last), .din(din), .ack(ack),
    .wfull(wfull), .winc(winc), .wdata(wdata), .busy(busy), .owner(owner)
  );

  int tests_run = 0;
  int fails = 0;

  logic [8:0] mem [4][32];
  int         head [4];
  int         tail [4];
  logic [3:0] hold;

  logic       s_winc, s_busy;
  logic [3:0] s_ack;
  logic [7:0] s_wdata;
  logic [1:0] s_owner;

  logic [7:0] log_data [64];
  int         log_src [64];
  int         nlog;

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (head[i] < tail[i] && !hold[i]) begin
        req[i]        = 1'b1;
        last[i]       = mem[i][head[i]][8];
        din[i*8 +: 8] = mem[i][head[i]][7:0];
      end else begin
        req[i]        = 1'b0;
        last[i]       = 1'b0;
        din[i*8 +: 8] = 8'h00;
      end
    end
  endtask

  task automatic load(input int i, input logic [7:0] d, input logic l);
    mem[i][tail[i]] = {l, d};
    tail[i]++;
  endtask

  task automatic load_pkt(input int i, input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) load(i, 8'(int'(base) + k), k == n-1);
  endtask

  // Sample the current cycle at the falling edge, then advance past the rising edge.
  task automatic step();
    int src;
    @(negedge wclk);
    s_winc  = winc;
    s_busy  = busy;
    s_ack   = ack;
    s_wdata = wdata;
    s_owner = owner;
    if (s_winc && nlog < 64) begin
      src = -1;
      for (int i = 0; i < 4; i++) if (s_ack[i]) src = i;
      log_data[nlog] = s_wdata;
      log_src[nlog]  = src;
      nlog++;
    end
    @(posedge wclk);
    #1;
    for (int i = 0; i < 4; i++) if (s_ack[i]) head[i]++;
    drive();
  endtask

  task automatic test_reset();
    wrst = 1'b1; wfull = 1'b0; hold = '0; nlog = 0;
    for (int i = 0; i < 4; i++) begin head[i] = 0; tail[i] = 0; end
    drive();
    step();
    step();
    tests_run++;
    if ({s_winc, s_ack, s_busy, s_owner, s_wdata} !== 16'h0) begin
      fails++;
      $display("FAIL reset_state: got winc=%b ack=%b busy=%b owner=%0d wdata=%h, expected all zero",
               s_winc, s_ack, s_busy, s_owner, s_wdata);
    end
    wrst = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0] ed [3];
    ed = '{8'h11, 8'h22, 8'h33};
    load(2, 8'h11, 1'b0); load(2, 8'h22, 1'b0); load(2, 8'h33, 1'b1);
    drive();
    step();
    tests_run++;
    if ({s_busy, s_winc} !== 2'b00) begin
      fails++;
      $display("FAIL single_arb: got busy=%b winc=%b, expected 0 0", s_busy, s_winc);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      tests_run++;
      if ({s_busy, s_owner, s_winc, s_ack, s_wdata} !== {1'b1, 2'd2, 1'b1, 4'b0100, ed[k]}) begin
        fails++;
        $display("FAIL single_word%0d: got busy=%b owner=%0d winc=%b ack=%b wdata=%h, expected 1 2 1 0100 %h",
                 k, s_busy, s_owner, s_winc, s_ack, s_wdata, ed[k]);
      end
    end
    step();
    tests_run++;
    if ({s_busy, s_winc} !== 2'b00) begin
      fails++;
      $display("FAIL single_release: got busy=%b winc=%b, expected 0 0", s_busy, s_winc);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] ed [4];
    int         es [4];
    ed = '{8'h63, 8'h60, 8'h61, 8'h64};
    es = '{3, 0, 1, 3};
    nlog = 0;
    load(1, 8'h61, 1'b1); load(3, 8'h63, 1'b1);
    drive();
    step();
    step();
    load(0, 8'h60, 1'b1); load(3, 8'h64, 1'b1);
    drive();
    for (int c = 0; c < 7; c++) begin
      step();
      if (c == 0) begin
        tests_run++;
        if (s_busy !== 1'b0) begin
          fails++;
          $display("FAIL wrap_bubble: got busy=%b, expected 0", s_busy);
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (log_src[k] !== es[k] || log_data[k] !== ed[k]) begin
        fails++;
        $display("FAIL wrap_order%0d: got src=%0d data=%h, expected src=%0d data=%h",
                 k, log_src[k], log_data[k], es[k], ed[k]);
      end
    end
  endtask

  task automatic test_fairness();
    logic [7:0] ed [10];
    int         es [10];
    ed = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h40, 8'h41};
    es = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    nlog = 0;
    load_pkt(0, 8'h00, 2); load_pkt(1, 8'h10, 2); load_pkt(2, 8'h20, 2);
    load_pkt(3, 8'h30, 2); load_pkt(0, 8'h40, 2);
    drive();
    for (int c = 0; c < 15; c++) begin
      step();
      tests_run++;
      if (s_winc !== ((c % 3) != 0)) begin
        fails++;
        $display("FAIL fair_winc_cycle%0d: got %b, expected %b", c, s_winc, (c % 3) != 0);
      end
    end
    for (int k = 0; k < 10; k++) begin
      tests_run++;
      if (log_src[k] !== es[k] || log_data[k] !== ed[k]) begin
        fails++;
        $display("FAIL fair_order%0d: got src=%0d data=%h, expected src=%0d data=%h",
                 k, log_src[k], log_data[k], es[k], ed[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    nlog = 0;
    load_pkt(1, 8'hA0, 4);
    drive();
    step(); step(); step();
    wfull = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      tests_run++;
      if ({s_winc, s_ack, s_busy, s_owner} !== {1'b0, 4'b0000, 1'b1, 2'd1}) begin
        fails++;
        $display("FAIL bp_full%0d: got winc=%b ack=%b busy=%b owner=%0d, expected 0 0000 1 1",
                 c, s_winc, s_ack, s_busy, s_owner);
      end
    end
    wfull = 1'b0;
    step();
    tests_run++;
    if ({s_winc, s_wdata} !== {1'b1, 8'hA2}) begin
      fails++;
      $display("FAIL bp_resume: got winc=%b wdata=%h, expected 1 a2", s_winc, s_wdata);
    end
    step(); step();
    tests_run++;
    if (nlog !== 4) begin
      fails++;
      $display("FAIL bp_count: got %0d words, expected 4", nlog);
    end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (log_src[k] !== 1 || log_data[k] !== 8'(8'hA0 + k)) begin
        fails++;
        $display("FAIL bp_word%0d: got src=%0d data=%h, expected src=1 data=%h",
                 k, log_src[k], log_data[k], 8'(8'hA0 + k));
      end
    end
  endtask

  task automatic test_req_drop();
    logic [7:0] ed [3];
    int         es [3];
    ed = '{8'h70, 8'h71, 8'h72};
    es = '{0, 0, 2};
    nlog = 0;
    load_pkt(0, 8'h70, 2);
    drive();
    step();
    load_pkt(2, 8'h72, 1);
    drive();
    step();
    hold[0] = 1'b1;
    drive();
    for (int c = 0; c < 2; c++) begin
      step();
      tests_run++;
      if ({s_winc, s_ack, s_busy, s_owner} !== {1'b0, 4'b0000, 1'b1, 2'd0}) begin
        fails++;
        $display("FAIL drop_hold%0d: got winc=%b ack=%b busy=%b owner=%0d, expected 0 0000 1 0",
                 c, s_winc, s_ack, s_busy, s_owner);
      end
    end
    hold[0] = 1'b0;
    drive();
    for (int c = 0; c < 4; c++) step();
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (log_src[k] !== es[k] || log_data[k] !== ed[k]) begin
        fails++;
        $display("FAIL drop_order%0d: got src=%0d data=%h, expected src=%0d data=%h",
                 k, log_src[k], log_data[k], es[k], ed[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] ed [7];
    int         es [7];
    int         start2;
    ed = '{8'h51, 8'h52, 8'h51, 8'h52, 8'h53, 8'h54, 8'h5A};
    es = '{2, 2, 2, 2, 2, 2, 3};
    nlog = 0;
    start2 = head[2];
    load_pkt(2, 8'h51, 4);
    drive();
    step(); step(); step();
    wrst = 1'b1;
    load_pkt(3, 8'h5A, 1);
    drive();
    step();
    tests_run++;
    if ({s_winc, s_ack} !== 5'b0) begin
      fails++;
      $display("FAIL rst_mid_winc: got winc=%b ack=%b, expected 0 0000", s_winc, s_ack);
    end
    wrst = 1'b0;
    head[2] = start2;
    drive();
    step();
    tests_run++;
    if ({s_busy, s_owner} !== 3'b000) begin
      fails++;
      $display("FAIL rst_mid_state: got busy=%b owner=%0d, expected 0 0", s_busy, s_owner);
    end
    for (int c = 0; c < 7; c++) step();
    for (int k = 0; k < 7; k++) begin
      tests_run++;
      if (log_src[k] !== es[k] || log_data[k] !== ed[k]) begin
        fails++;
        $display("FAIL rst_mid_order%0d: got src=%0d data=%h, expected src=%0d data=%h",
                 k, log_src[k], log_data[k], es[k], ed[k]);
      end
    end
  endtask

  task automatic test_burst();
    logic [7:0] ed [8];
    int         es [8];
`ifdef ASYNC_FIFO_WR_ARB_BURST_LIMIT_EN
    ed = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h90, 8'h91, 8'h84, 8'h85};
    es = '{1, 1, 1, 1, 2, 2, 1, 1};
`else
    ed = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h90, 8'h91};
    es = '{1, 1, 1, 1, 1, 1, 2, 2};
`endif
    nlog = 0;
    load_pkt(1, 8'h80, 6);
    load_pkt(2, 8'h90, 2);
    drive();
    for (int c = 0; c < 14; c++) step();
    tests_run++;
    if (nlog !== 8) begin
      fails++;
      $display("FAIL burst_count: got %0d words, expected 8", nlog);
    end
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (log_src[k] !== es[k] || log_data[k] !== ed[k]) begin
        fails++;
        $display("FAIL burst_order%0d: got src=%0d data=%h, expected src=%0d data=%h",
                 k, log_src[k], log_data[k], es[k], ed[k]);
      end
    end
  endtask

  initial begin
    req = '0; last = '0; din = '0;
    test_reset();
    test_single();
    test_wrap();
    test_fairness();
    test_backpressure();
    test_req_drop();
    test_reset_mid();
    test_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
